// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: state encodings, fixed opcodes and the IR capture pattern.
package jtag_tap_pkg;

  // IEEE 1149.1 reference state encoding.
  typedef enum logic [3:0] {
    ST_EXIT2_DR = 4'h0,
    ST_EXIT1_DR = 4'h1,
    ST_SHIFT_DR = 4'h2,
    ST_PAUSE_DR = 4'h3,
    ST_SEL_IR   = 4'h4,
    ST_UPD_DR   = 4'h5,
    ST_CAP_DR   = 4'h6,
    ST_SEL_DR   = 4'h7,
    ST_EXIT2_IR = 4'h8,
    ST_EXIT1_IR = 4'h9,
    ST_SHIFT_IR = 4'hA,
    ST_PAUSE_IR = 4'hB,
    ST_RTI      = 4'hC,
    ST_UPD_IR   = 4'hD,
    ST_CAP_IR   = 4'hE,
    ST_TLR      = 4'hF
  } tap_state_e;

  localparam int OP_EXTEST         = 0;
  localparam int OP_SAMPLE_PRELOAD = 1;
  localparam int OP_IDCODE         = 2;

  // Upper IR bits capture as zero; only the two LSBs are fixed by the standard.
  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

  function automatic int unsigned bypass_opcode(input int unsigned ir_width);
    return (32'd1 << ir_width) - 32'd1;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller; status outputs decode the current state directly.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_e state,
  output logic       test_logic_reset,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       pause_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      state <= ST_TLR;
    end else begin
      unique case (state)
        ST_TLR:      state <= tms ? ST_TLR      : ST_RTI;
        ST_RTI:      state <= tms ? ST_SEL_DR   : ST_RTI;
        ST_SEL_DR:   state <= tms ? ST_SEL_IR   : ST_CAP_DR;
        ST_CAP_DR:   state <= tms ? ST_EXIT1_DR : ST_SHIFT_DR;
        ST_SHIFT_DR: state <= tms ? ST_EXIT1_DR : ST_SHIFT_DR;
        ST_EXIT1_DR: state <= tms ? ST_UPD_DR   : ST_PAUSE_DR;
        ST_PAUSE_DR: state <= tms ? ST_EXIT2_DR : ST_PAUSE_DR;
        ST_EXIT2_DR: state <= tms ? ST_UPD_DR   : ST_SHIFT_DR;
        ST_UPD_DR:   state <= tms ? ST_SEL_DR   : ST_RTI;
        ST_SEL_IR:   state <= tms ? ST_TLR      : ST_CAP_IR;
        ST_CAP_IR:   state <= tms ? ST_EXIT1_IR : ST_SHIFT_IR;
        ST_SHIFT_IR: state <= tms ? ST_EXIT1_IR : ST_SHIFT_IR;
        ST_EXIT1_IR: state <= tms ? ST_UPD_IR   : ST_PAUSE_IR;
        ST_PAUSE_IR: state <= tms ? ST_EXIT2_IR : ST_PAUSE_IR;
        ST_EXIT2_IR: state <= tms ? ST_UPD_IR   : ST_SHIFT_IR;
        ST_UPD_IR:   state <= tms ? ST_SEL_DR   : ST_RTI;
        default:     state <= ST_TLR;
      endcase
    end
  end

  assign test_logic_reset = (state == ST_TLR);
  assign capture_dr       = (state == ST_CAP_DR);
  assign shift_dr         = (state == ST_SHIFT_DR);
  assign pause_dr         = (state == ST_PAUSE_DR);
  assign update_dr        = (state == ST_UPD_DR);
  assign capture_ir       = (state == ST_CAP_IR);
  assign shift_ir         = (state == ST_SHIFT_IR);
  assign update_ir        = (state == ST_UPD_IR);

endmodule

// File: rtl/jtag_tap_multichain.sv
// Parametrised TAP with IDCODE, BYPASS and NUM_CHAINS user chains muxed onto TDO.
module jtag_tap_multichain
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH     = 4,
  parameter int          NUM_CHAINS   = 4,
  parameter int          CHAIN_BASE   = 8,
  parameter logic [31:0] IDCODE_VALUE = 32'h149511C3
) (
  input  logic                  tck_pad_i,
  input  logic                  trst_pad_i,
  input  logic                  tms_pad_i,
  input  logic                  tdi_pad_i,
  output logic                  tdo_pad_o,
  output logic                  tdo_padoe_o,
  output logic                  test_logic_reset_o,
  output logic                  shift_dr_o,
  output logic                  capture_dr_o,
  output logic                  pause_dr_o,
  output logic                  update_dr_o,
  output logic                  tdo_o,
  output logic [NUM_CHAINS-1:0] chain_select_o,
  input  logic [NUM_CHAINS-1:0] chain_tdi_i,
  output logic [IR_WIDTH-1:0]   ir_o
);

  localparam logic [IR_WIDTH-1:0] IR_EXTEST  = IR_WIDTH'(OP_EXTEST);
  localparam logic [IR_WIDTH-1:0] IR_SAMPLE  = IR_WIDTH'(OP_SAMPLE_PRELOAD);
  localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_BYPASS  = IR_WIDTH'(bypass_opcode(IR_WIDTH));
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_LSBS);

  tap_state_e tap_state;
  logic       capture_ir, shift_ir, update_ir;

  jtag_tap_fsm u_fsm (
    .tck              (tck_pad_i),
    .trst             (trst_pad_i),
    .tms              (tms_pad_i),
    .state            (tap_state),
    .test_logic_reset (test_logic_reset_o),
    .capture_dr       (capture_dr_o),
    .shift_dr         (shift_dr_o),
    .pause_dr         (pause_dr_o),
    .update_dr        (update_dr_o),
    .capture_ir       (capture_ir),
    .shift_ir         (shift_ir),
    .update_ir        (update_ir)
  );

  logic [IR_WIDTH-1:0]   ir_sr;
  logic [31:0]           idcode_sr;
  logic                  bypass_q;
  logic [NUM_CHAINS-1:0] chain_hit;
  logic                  dr_tdo;
  logic                  sel_idcode;

  assign sel_idcode = (ir_o == IR_IDCODE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    chain_hit = '0;
    for (int k = 0; k < NUM_CHAINS; k++) begin
      chain_hit[k] = (ir_o == IR_WIDTH'(CHAIN_BASE + k));
    end
  end

  assign chain_select_o = chain_hit;

  // Unknown opcodes and out-of-range chain opcodes fall through to the bypass bit.
  always_comb begin
    dr_tdo = bypass_q;
    if (sel_idcode) begin
      dr_tdo = idcode_sr[0];
    end else if (ir_o == IR_EXTEST || ir_o == IR_SAMPLE) begin
      dr_tdo = chain_tdi_i[0];
    end else if (|chain_hit) begin
      dr_tdo = |(chain_tdi_i & chain_hit);
    end else if (ir_o == IR_BYPASS) begin
      dr_tdo = bypass_q;
    end
  end

  always_ff @(posedge tck_pad_i or posedge trst_pad_i) begin
    if (trst_pad_i) begin
      ir_sr     <= '0;
      ir_o      <= IR_IDCODE;
      idcode_sr <= IDCODE_VALUE;
      bypass_q  <= 1'b0;
      tdo_o     <= 1'b0;
    end else begin
      tdo_o <= tdi_pad_i;

      if (capture_ir)    ir_sr <= IR_CAPTURE;
      else if (shift_ir) ir_sr <= {tdi_pad_i, ir_sr[IR_WIDTH-1:1]};

      if (tap_state == ST_TLR) ir_o <= IR_IDCODE;
      else if (update_ir)      ir_o <= ir_sr;

      if (capture_dr_o && sel_idcode)    idcode_sr <= IDCODE_VALUE;
      else if (shift_dr_o && sel_idcode) idcode_sr <= {tdi_pad_i, idcode_sr[31:1]};

      if (capture_dr_o)    bypass_q <= 1'b0;
      else if (shift_dr_o) bypass_q <= tdi_pad_i;
    end
  end

  // TDO changes on the falling edge so the probe samples it stable on the next rising edge.
  always_ff @(negedge tck_pad_i or posedge trst_pad_i) begin
    if (trst_pad_i) begin
      tdo_pad_o   <= 1'b0;
      tdo_padoe_o <= 1'b0;
    end else begin
      tdo_padoe_o <= shift_ir | shift_dr_o;
      if (shift_ir)        tdo_pad_o <= ir_sr[0];
      else if (shift_dr_o) tdo_pad_o <= dr_tdo;
      else                 tdo_pad_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_tap_multichain.sv
// Directed bench for jtag_tap_multichain; expected TDO bits queued when a scan starts.
module tb_jtag_tap_multichain;

  localparam int          IR_WIDTH   = 4;
  localparam int          NUM_CHAINS = 4;
  localparam int          CHAIN_BASE = 8;
  localparam logic [31:0] IDCODE     = 32'h149511C3;

  logic                  tck = 1'b0;
  logic                  trst, tms, tdi;
  logic                  tdo_pad, tdo_padoe, tlr, shift_dr, capture_dr, pause_dr, update_dr, tdo_chain;
  logic [NUM_CHAINS-1:0] chain_select, chain_tdi;
  logic [IR_WIDTH-1:0]   ir;

  int   tests = 0;
  int   fails = 0;
  int   cap_cnt = 0;
  int   upd_cnt = 0;
  logic exp_q[$];

  jtag_tap_multichain #(
    .IR_WIDTH(IR_WIDTH), .NUM_CHAINS(NUM_CHAINS), .CHAIN_BASE(CHAIN_BASE), .IDCODE_VALUE(IDCODE)
  ) dut (
    .tck_pad_i          (tck),
    .trst_pad_i         (trst),
    .tms_pad_i          (tms),
    .tdi_pad_i          (tdi),
    .tdo_pad_o          (tdo_pad),
    .tdo_padoe_o        (tdo_padoe),
    .test_logic_reset_o (tlr),
    .shift_dr_o         (shift_dr),
    .capture_dr_o       (capture_dr),
    .pause_dr_o         (pause_dr),
    .update_dr_o        (update_dr),
    .tdo_o              (tdo_chain),
    .chain_select_o     (chain_select),
    .chain_tdi_i        (chain_tdi),
    .ir_o               (ir)
  );

  always #5 tck = ~tck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive TMS/TDI, take one rising and one falling edge, settle just after the fall.
  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    @(negedge tck);
    #1;
    if (capture_dr) cap_cnt++;
    if (update_dr)  upd_cnt++;
  endtask

  task automatic push_bits(input int n, input logic [63:0] bits);
    for (int i = 0; i < n; i++) exp_q.push_back(bits[i]);
  endtask

  // Already in a Shift state; each bit pops one expectation, optional TMS=1 on the last.
  task automatic shift_bits(input int n, input logic [63:0] din, input bit exit_last);
    logic e;
    for (int i = 0; i < n; i++) begin
      check("tdo_oe", tdo_padoe, 1'b1);
      if (exp_q.size() == 0) begin
        check("queue_underflow", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("tdo_bit", tdo_pad, e);
      end
      step(exit_last && (i == n - 1), din[i]);
    end
  endtask

  task automatic to_shift_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic to_shift_ir();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic finish_scan();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [IR_WIDTH-1:0] value);
    to_shift_ir();
    push_bits(IR_WIDTH, 64'b0001);
    shift_bits(IR_WIDTH, 64'(value), 1'b1);
    finish_scan();
    check("ir_after_update", ir, value);
  endtask

  initial begin
    trst      = 1'b1;
    tms       = 1'b1;
    tdi       = 1'b0;
    chain_tdi = '0;
    repeat (2) @(posedge tck);
    @(negedge tck);
    #1;
    trst = 1'b0;
    check("rst_ir", ir, 4'h2);
    check("rst_chain_select", chain_select, 4'b0000);
    check("rst_tdo_oe", tdo_padoe, 1'b0);
    check("rst_tdo", tdo_pad, 1'b0);
    check("rst_tlr", tlr, 1'b1);

    // IDCODE scan split by a pause: shift registers must hold across Exit1/Pause/Exit2.
    step(1'b0, 1'b0);
    check("rti_tlr_low", tlr, 1'b0);
    cap_cnt = 0;
    to_shift_dr();
    check("in_shift_dr", shift_dr, 1'b1);
    push_bits(16, 64'(IDCODE[15:0]));
    shift_bits(16, 64'h0, 1'b1);
    step(1'b0, 1'b0);
    check("in_pause_dr", pause_dr, 1'b1);
    check("pause_tdo_oe", tdo_padoe, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    push_bits(16, 64'(IDCODE[31:16]));
    shift_bits(16, 64'h0, 1'b1);
    finish_scan();
    check("idcode_capture_once", cap_cnt, 1);
    check("post_scan_tdo_oe", tdo_padoe, 1'b0);

    step(1'b0, 1'b1);
    check("tdo_chain_1", tdo_chain, 1'b1);
    step(1'b0, 1'b0);
    check("tdo_chain_0", tdo_chain, 1'b0);

    // BYPASS: captured 0 first, then TDI delayed one bit (TDI 1,1,0,1,0).
    load_ir(4'hF);
    to_shift_dr();
    push_bits(5, 64'b10110);
    shift_bits(5, 64'b01011, 1'b1);
    finish_scan();

    // Update-IR with no shifts loads the capture value: SAMPLE_PRELOAD routes chain 0.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("zero_shift_ir", ir, 4'h1);
    check("sample_chain_select", chain_select, 4'b0000);
    chain_tdi = 4'b0001;
    to_shift_dr();
    push_bits(2, 64'b11);
    shift_bits(2, 64'b11, 1'b1);
    finish_scan();

    // Chain 2: select, return data and single capture/update pulse per scan.
    load_ir(4'hA);
    check("chain2_select", chain_select, 4'b0100);
    chain_tdi = 4'b0100;
    cap_cnt   = 0;
    upd_cnt   = 0;
    to_shift_dr();
    push_bits(4, 64'b1111);
    shift_bits(4, 64'h0, 1'b1);
    finish_scan();
    check("chain2_capture_pulses", cap_cnt, 1);
    check("chain2_update_pulses", upd_cnt, 1);
    chain_tdi = 4'b1011;
    to_shift_dr();
    push_bits(2, 64'b00);
    shift_bits(2, 64'b11, 1'b1);
    finish_scan();
    check("chain2_select_kept", chain_select, 4'b0100);

    // First opcode past the last chain, then an unmapped one: both behave as bypass.
    load_ir(4'hC);
    check("ir_c_select", chain_select, 4'b0000);
    to_shift_dr();
    push_bits(3, 64'b010);
    shift_bits(3, 64'b101, 1'b1);
    finish_scan();
    load_ir(4'hE);
    check("ir_e_select", chain_select, 4'b0000);
    to_shift_dr();
    push_bits(3, 64'b100);
    shift_bits(3, 64'b110, 1'b1);
    finish_scan();

    // Asynchronous reset two bits into an IR shift.
    to_shift_ir();
    push_bits(2, 64'b01);
    shift_bits(2, 64'b11, 1'b0);
    trst = 1'b1;
    #2;
    check("async_rst_tlr", tlr, 1'b1);
    check("async_rst_ir", ir, 4'h2);
    check("async_rst_tdo_oe", tdo_padoe, 1'b0);
    @(negedge tck);
    #1;
    trst = 1'b0;

    // Five TMS=1 clocks from Shift-DR reach Test-Logic-Reset; IR reloads to IDCODE there.
    step(1'b0, 1'b0);
    load_ir(4'hF);
    to_shift_dr();
    repeat (5) step(1'b1, 1'b0);
    check("tms5_tlr", tlr, 1'b1);
    step(1'b1, 1'b0);
    check("tms5_ir", ir, 4'h2);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtag_tap_multichain.md
Name: jtag_tap_multichain

Overview:
- Parametrised IEEE 1149.1 TAP controller; next generation of the fixed-format TAP currently used behind the Trace32 JTAG transactor.
- Adds configurable IR width and IDCODE value, plus NUM_CHAINS independently selectable user data chains (debug, MBIST, boundary scan, ...).
- Drives per-chain select and shared TAP strobes; muxes the selected chain's return data onto TDO.
- Sits between the JTAG pads (or the simulation transactor) and the on-chip debug/test chains.

Parameters:
- IR_WIDTH, 4, instruction register width in bits, minimum 2.
- NUM_CHAINS, 4, number of user data chains, 1..(2^IR_WIDTH - 4).
- CHAIN_BASE, 8, opcode of chain 0; chain k uses opcode CHAIN_BASE+k.
- IDCODE_VALUE, 32'h149511C3, IDCODE register content; bit 0 must be 1.

Ports:
- tck_pad_i  input  1  TCK; the only clock.
- trst_pad_i  input  1  asynchronous, active-high TAP reset.
- tms_pad_i  input  1  TMS.
- tdi_pad_i  input  1  TDI.
- tdo_pad_o  output  1  TDO.
- tdo_padoe_o  output  1  TDO output enable.
- test_logic_reset_o  output  1  high while in Test-Logic-Reset.
- shift_dr_o  output  1  high while in Shift-DR.
- capture_dr_o  output  1  high while in Capture-DR.
- pause_dr_o  output  1  high while in Pause-DR.
- update_dr_o  output  1  high while in Update-DR.
- tdo_o  output  1  serial data to chains (registered copy of TDI).
- chain_select_o  output  NUM_CHAINS  one-hot chain select; all zero if no chain opcode.
- chain_tdi_i  input  NUM_CHAINS  serial return data from each chain.
- ir_o  output  IR_WIDTH  current (updated) instruction.

Behaviour:
- Reset (trst_pad_i high, async) sets:
  - FSM = Test-Logic-Reset; ir_o = IDCODE opcode (2).
  - tdo_pad_o = 0, tdo_padoe_o = 0, chain_select_o = 0.
  - IR shift register = 0; IDCODE shift register = IDCODE_VALUE; bypass = 0.
- FSM: standard 16-state TAP, transitions on rising tck_pad_i per TMS.
  - Five TCKs with TMS=1 reach Test-Logic-Reset from any state.
  - Entering Test-Logic-Reset synchronously reloads ir_o = IDCODE.
- Status outputs are combinational decodes of the current state, with no extra latency.
- Opcodes:
  - 0 = EXTEST; 1 = SAMPLE_PRELOAD; 2 = IDCODE.
  - CHAIN_BASE+k = chain k.
  - all-ones = BYPASS.
  - Any other opcode behaves as BYPASS.
- IR path:
  - Capture-IR loads binary ...0001 (LSB=1, bit1=0).
  - Shift-IR shifts LSB-first, TDI entering at MSB.
  - Update-IR copies the shift register to ir_o.
- DR path:
  - IDCODE: Capture-DR loads IDCODE_VALUE; Shift-DR shifts LSB-first.
  - BYPASS: Capture-DR clears the 1-bit register; Shift-DR loads TDI.
  - Chain k: chain_select_o[k] = 1 whenever ir_o selects k, in any state. Chain data comes from chain_tdi_i[k]; chains latch tdo_o.
  - EXTEST and SAMPLE_PRELOAD route to chain_tdi_i[0]; the boundary scan chain is chain 0 by convention.
- TDO:
  - Registered on the falling edge of tck_pad_i.
  - In Shift-IR: IR shift register LSB. In Shift-DR: source selected by ir_o.
  - tdo_padoe_o = 1 only while Shift-IR or Shift-DR is latched on the falling edge; tdo_pad_o = 0 otherwise.
- tdo_o: TDI registered on the rising edge, so chains see TDI one cycle later.
- Boundary conditions:
  - Reset mid-shift aborts without updating ir_o.
  - Exit1/Pause/Exit2 hold the shift registers.
  - Update with zero shifts reloads the captured value, e.g. IR capture value 1 = SAMPLE_PRELOAD.
  - Chain opcodes at or above CHAIN_BASE+NUM_CHAINS decode as BYPASS.

Decomposition:
- Package jtag_tap_pkg holds:
  - the 16 TAP state encodings (4-bit);
  - opcode constants for EXTEST, SAMPLE_PRELOAD and IDCODE;
  - IR capture pattern;
  - a function returning the BYPASS opcode for a given IR_WIDTH.
- Sub-module jtag_tap_fsm (tck, trst, tms -> state, state decodes); the top holds the IR, DR registers, decode and TDO mux.

Test Plan:
- Hold trst_pad_i high 2 cycles, release → ir_o=2, chain_select_o=0, tdo_padoe_o=0, test_logic_reset_o=1.
- From Run-Test/Idle, enter Shift-DR and shift 32 bits → TDO sequence equals IDCODE_VALUE LSB-first (first bit 1).
- Shift-IR with TDI=4'b1111 → TDO shows 1,0,0,0 (capture pattern); after Update-IR, ir_o=4'hF; DR shift of pattern 1011 returns the same pattern delayed 1 bit (BYPASS).
- Load IR=CHAIN_BASE+2 (4'hA) → chain_select_o=4'b0100; drive chain_tdi_i[2]=1, others 0 → TDO=1 during Shift-DR; capture_dr_o, update_dr_o each pulse for exactly one cycle per DR scan.
- Load IR=4'hE (unmapped) → chain_select_o=0 and 1-bit bypass behaviour.
- Assert trst_pad_i midway through Shift-IR after 2 of 4 bits → immediate Test-Logic-Reset and ir_o=2 with no clock edge; TMS=1 for 5 TCKs from Shift-DR also returns to Test-Logic-Reset.
